// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry and receiver state encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_pkg;

  // Default number of data bits per frame.
  localparam int UART_DATA_SIZE = 8;

  // Line bits per frame: start + data + parity + stop.
  localparam int FRAME_BITS = UART_DATA_SIZE + 3;

  // Receiver states, one-hot like the transmitter's state type.
  typedef enum logic [4:0] {
    RX_IDLE      = 5'b00001,
    RX_DATA      = 5'b00010,
    RX_PARITY    = 5'b00100,
    RX_STOP      = 5'b01000,
    RX_WAIT_IDLE = 5'b10000
  } rx_state_t;

endpackage

// File: rtl/uart_receiver_if.sv
// Receiver-side bundle: serial line and FIFO-full in, frame data and status pulses out.
// Latency: n/a (wiring only).
// Backpressure: fifo_full from the RX FIFO; a full FIFO drops the frame with an overrun pulse.
interface uart_receiver_if #(
  parameter int DATA_SIZE = uart_pkg::UART_DATA_SIZE
);

  logic                 serial_data_in;
  logic                 fifo_full;
  logic [DATA_SIZE-1:0] data_out;
  logic                 rx_done;
  logic                 parity_error;
  logic                 framing_error;
  logic                 overrun_error;

  // The receiver drives the frame results and consumes the line.
  modport master (
    input  serial_data_in,
    input  fifo_full,
    output data_out,
    output rx_done,
    output parity_error,
    output framing_error,
    output overrun_error
  );

  // The line/FIFO side drives the line and full flag and consumes results.
  modport slave (
    output serial_data_in,
    output fifo_full,
    input  data_out,
    input  rx_done,
    input  parity_error,
    input  framing_error,
    input  overrun_error
  );

endinterface

// File: rtl/uart_receiver.sv
// UART receive deserialiser: start, DATA_SIZE bits LSB first, parity, stop; one line bit per clk.
// Latency: result pulses are high for the single cycle after the stop-bit edge.
// Backpressure: fifo_full sampled on the stop edge; when set a good frame is dropped with overrun_error.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int DATA_SIZE      = UART_DATA_SIZE,
  parameter bit PARITY_ODD     = 1'b0,
  parameter int BIT_COUNT_SIZE = $clog2(DATA_SIZE + 2)
) (
  input  logic            clk,
  input  logic            reset_n,
  uart_receiver_if.master rx
);

  // Legacy-compatible state constants taken from the shared one-hot encoding.
  localparam logic [4:0] S_IDLE      = RX_IDLE;
  localparam logic [4:0] S_DATA      = RX_DATA;
  localparam logic [4:0] S_PARITY    = RX_PARITY;
  localparam logic [4:0] S_STOP      = RX_STOP;
  localparam logic [4:0] S_WAIT_IDLE = RX_WAIT_IDLE;

  localparam logic [BIT_COUNT_SIZE-1:0] LAST_BIT = BIT_COUNT_SIZE'(DATA_SIZE - 1);

  logic [4:0]                state_q, state_d;
  logic [BIT_COUNT_SIZE-1:0] bit_count_q, bit_count_d;
  logic [DATA_SIZE-1:0]      shift_q, shift_d;
  logic                      parity_q, parity_d;
  logic [DATA_SIZE-1:0]      data_out_q, data_out_d;
  logic                      rx_done_q, rx_done_d;
  logic                      parity_error_q, parity_error_d;
  logic                      framing_error_q, framing_error_d;
  logic                      overrun_error_q, overrun_error_d;
  logic                      parity_bad;

  // Non-zero when the received parity bit disagrees with the data under the chosen sense.
  assign parity_bad = (^shift_q) ^ parity_q ^ PARITY_ODD;

  // Frame sequencing, bit capture and stop-edge resolution (framing > overrun > accept).
  always_comb begin
    state_d         = state_q;
    bit_count_d     = bit_count_q;
    shift_d         = shift_q;
    parity_d        = parity_q;
    data_out_d      = data_out_q;
    rx_done_d       = 1'b0;
    parity_error_d  = 1'b0;
    framing_error_d = 1'b0;
    overrun_error_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!rx.serial_data_in) begin
          state_d     = S_DATA;
          bit_count_d = '0;
        end
      end

      S_DATA: begin
        // Shift right from the MSB so the first (LSB) bit lands in bit 0.
        shift_d     = {rx.serial_data_in, shift_q[DATA_SIZE-1:1]};
        bit_count_d = bit_count_q + BIT_COUNT_SIZE'(1);
        if (bit_count_q == LAST_BIT) begin
          state_d = S_PARITY;
        end
      end

      S_PARITY: begin
        parity_d = rx.serial_data_in;
        state_d  = S_STOP;
      end

      S_STOP: begin
        if (!rx.serial_data_in) begin
          // Bad stop bit: discard everything and wait for the line to release.
          framing_error_d = 1'b1;
          state_d         = S_WAIT_IDLE;
        end else if (rx.fifo_full) begin
          overrun_error_d = 1'b1;
          parity_error_d  = parity_bad;
          state_d         = S_IDLE;
        end else begin
          // Data is delivered even on a parity mismatch; the flag rides alongside.
          data_out_d     = shift_q;
          rx_done_d      = 1'b1;
          parity_error_d = parity_bad;
          state_d        = S_IDLE;
        end
      end

      S_WAIT_IDLE: begin
        // A held-low (break) line must not look like a stream of start bits.
        if (rx.serial_data_in) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q         <= S_IDLE;
      bit_count_q     <= '0;
      shift_q         <= '0;
      parity_q        <= 1'b0;
      data_out_q      <= '0;
      rx_done_q       <= 1'b0;
      parity_error_q  <= 1'b0;
      framing_error_q <= 1'b0;
      overrun_error_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      bit_count_q     <= bit_count_d;
      shift_q         <= shift_d;
      parity_q        <= parity_d;
      data_out_q      <= data_out_d;
      rx_done_q       <= rx_done_d;
      parity_error_q  <= parity_error_d;
      framing_error_q <= framing_error_d;
      overrun_error_q <= overrun_error_d;
    end
  end

  assign rx.data_out      = data_out_q;
  assign rx.rx_done       = rx_done_q;
  assign rx.parity_error  = parity_error_q;
  assign rx.framing_error = framing_error_q;
  assign rx.overrun_error = overrun_error_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver: even- and odd-parity instances share one serial line and FIFO-full flag.
// Latency: results expected in the cycle after the stop edge.
// Backpressure: fifo_full driven per frame.
module tb_uart_receiver;
  import uart_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic line = 1'b1;
  logic full_in = 1'b0;

  always #5 clk = ~clk;

  uart_receiver_if #(.DATA_SIZE(8)) if_e ();
  uart_receiver_if #(.DATA_SIZE(8)) if_o ();

  assign if_e.serial_data_in = line;
  assign if_e.fifo_full      = full_in;
  assign if_o.serial_data_in = line;
  assign if_o.fifo_full      = full_in;

  uart_receiver #(.DATA_SIZE(8), .PARITY_ODD(1'b0)) dut_e (.clk(clk), .reset_n(reset_n), .rx(if_e));
  uart_receiver #(.DATA_SIZE(8), .PARITY_ODD(1'b1)) dut_o (.clk(clk), .reset_n(reset_n), .rx(if_o));

  logic [3:0] flags_e, flags_o;
  assign flags_e = {if_e.rx_done, if_e.parity_error, if_e.framing_error, if_e.overrun_error};
  assign flags_o = {if_o.rx_done, if_o.parity_error, if_o.framing_error, if_o.overrun_error};

  int n_checks = 0;
  int n_pass = 0;

  // Reference model state: last accepted data and expected pulse totals.
  logic [7:0] exp_data = 8'h00;
  int exp_rx = 0, exp_pe_e = 0, exp_pe_o = 0, exp_fe = 0, exp_oe = 0;

  // Observed pulse totals (each pulse is high for one cycle, counted once).
  int cnt_rx_e = 0, cnt_rx_o = 0, cnt_pe_e = 0, cnt_pe_o = 0, cnt_fe = 0, cnt_oe = 0;
  always @(posedge clk) begin
    cnt_rx_e <= cnt_rx_e + int'(if_e.rx_done);
    cnt_rx_o <= cnt_rx_o + int'(if_o.rx_done);
    cnt_pe_e <= cnt_pe_e + int'(if_e.parity_error);
    cnt_pe_o <= cnt_pe_o + int'(if_o.parity_error);
    cnt_fe   <= cnt_fe + int'(if_e.framing_error);
    cnt_oe   <= cnt_oe + int'(if_e.overrun_error);
  end

  function automatic logic even_par(input logic [7:0] d);
    return ($countones(d) % 2) == 1;
  endfunction

  task automatic idle(input int n);
    line = 1'b1;
    full_in = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Drives one frame (start, LSB-first data, parity, stop) and checks the result cycle.
  // no_wait drives the start bit immediately, giving one-stop-bit spacing after a previous frame.
  task automatic send_frame(input string tag, input logic [7:0] d, input logic par,
                            input logic stop, input logic full, input bit no_wait);
    logic [FRAME_BITS-1:0] bits;
    int ones;
    logic rx, pe_e, pe_o, fe, oe;
    bits = {stop, par, d, 1'b0};
    for (int i = 0; i < FRAME_BITS; i++) begin
      if (!(i == 0 && no_wait)) @(negedge clk);
      if (i == FRAME_BITS - 1) begin
        n_checks++;
        if ({flags_e, flags_o} !== 8'h00)
          $display("FAIL %s early_pulse: got %b want 00000000", tag, {flags_e, flags_o});
        else n_pass++;
      end
      line = bits[i];
      full_in = full;
    end
    @(negedge clk);
    ones = $countones(d) + int'(par);
    fe   = !stop;
    oe   = stop && full;
    rx   = stop && !full;
    pe_e = stop && (ones % 2 == 1);
    pe_o = stop && (ones % 2 == 0);
    if (rx) exp_data = d;
    exp_rx   += int'(rx);
    exp_pe_e += int'(pe_e);
    exp_pe_o += int'(pe_o);
    exp_fe   += int'(fe);
    exp_oe   += int'(oe);
    n_checks++;
    if (flags_e !== {rx, pe_e, fe, oe})
      $display("FAIL %s flags_even: got %b want %b", tag, flags_e, {rx, pe_e, fe, oe});
    else n_pass++;
    n_checks++;
    if (flags_o !== {rx, pe_o, fe, oe})
      $display("FAIL %s flags_odd: got %b want %b", tag, flags_o, {rx, pe_o, fe, oe});
    else n_pass++;
    n_checks++;
    if (if_e.data_out !== exp_data)
      $display("FAIL %s data_even: got %h want %h", tag, if_e.data_out, exp_data);
    else n_pass++;
    n_checks++;
    if (if_o.data_out !== exp_data)
      $display("FAIL %s data_odd: got %h want %h", tag, if_o.data_out, exp_data);
    else n_pass++;
    line = 1'b1;
    full_in = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    idle(3);
    n_checks++;
    if ({flags_e, flags_o, if_e.data_out, if_o.data_out} !== 24'h0)
      $display("FAIL reset_state: got %h want 000000", {flags_e, flags_o, if_e.data_out, if_o.data_out});
    else n_pass++;
    reset_n = 1'b1;
    idle(2);
  endtask

  task automatic test_basic();
    send_frame("a5", 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    n_checks++;
    if ({flags_e, flags_o} !== 8'h00)
      $display("FAIL a5_one_cycle: got %b want 00000000", {flags_e, flags_o});
    else n_pass++;
    idle(2);
  endtask

  task automatic test_parity();
    send_frame("3c_par1", 8'h3C, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(2);
    send_frame("e7_par_ok", 8'hE7, even_par(8'hE7), 1'b1, 1'b0, 1'b0);
    idle(2);
  endtask

  task automatic test_framing();
    logic [7:0] held;
    send_frame("5a_stop0", 8'h5A, even_par(8'h5A), 1'b0, 1'b0, 1'b0);
    held = exp_data;
    line = 1'b0;
    repeat (5) @(negedge clk);
    idle(14);
    n_checks++;
    if ({flags_e, if_e.data_out} !== {4'h0, held})
      $display("FAIL break_hold: got %h want %h", {flags_e, if_e.data_out}, {4'h0, held});
    else n_pass++;
    send_frame("81_after_break", 8'h81, even_par(8'h81), 1'b1, 1'b0, 1'b0);
    idle(2);
  endtask

  task automatic test_overrun();
    send_frame("77_full", 8'h77, even_par(8'h77), 1'b1, 1'b1, 1'b0);
    idle(2);
    send_frame("12_after_full", 8'h12, even_par(8'h12), 1'b1, 1'b0, 1'b0);
    idle(2);
  endtask

  task automatic test_back_to_back();
    logic [7:0] seq [4];
    seq = '{8'h00, 8'hFF, 8'h55, 8'hAA};
    for (int i = 0; i < 4; i++)
      send_frame($sformatf("b2b%0d", i), seq[i], even_par(seq[i]), 1'b1, 1'b0, i != 0);
    idle(3);
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] d;
    d = 8'hC3;
    @(negedge clk); line = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); line = d[i];
    end
    @(negedge clk); reset_n = 1'b0; line = d[3];
    @(negedge clk); reset_n = 1'b1; line = 1'b1;
    exp_data = 8'h00;
    n_checks++;
    if ({flags_e, flags_o, if_e.data_out, if_o.data_out} !== 24'h0)
      $display("FAIL mid_reset_state: got %h want 000000", {flags_e, flags_o, if_e.data_out, if_o.data_out});
    else n_pass++;
    idle(14);
    n_checks++;
    if ({flags_e, flags_o, if_e.data_out} !== 16'h0)
      $display("FAIL mid_reset_quiet: got %h want 0000", {flags_e, flags_o, if_e.data_out});
    else n_pass++;
    send_frame("3e_after_reset", 8'h3E, even_par(8'h3E), 1'b1, 1'b0, 1'b0);
    idle(2);
  endtask

  task automatic test_random();
    logic [7:0] d;
    logic par, stop, full;
    bit prev_stop;
    prev_stop = 1'b0;
    for (int i = 0; i < 30; i++) begin
      d    = 8'($urandom);
      par  = even_par(d) ^ ($urandom_range(0, 3) == 0);
      stop = ($urandom_range(0, 7) != 0);
      full = ($urandom_range(0, 5) == 0);
      if (!(prev_stop && $urandom_range(0, 1) == 1)) idle($urandom_range(0, 2));
      send_frame($sformatf("rnd%0d", i), d, par, stop, full,
                 prev_stop && line === 1'b1 && full_in === 1'b0 && $urandom_range(0, 1) == 1);
      prev_stop = stop;
    end
    idle(3);
  endtask

  task automatic test_pulse_counts();
    idle(3);
    n_checks++;
    if (cnt_rx_e !== exp_rx) $display("FAIL count_rx_even: got %0d want %0d", cnt_rx_e, exp_rx);
    else n_pass++;
    n_checks++;
    if (cnt_rx_o !== exp_rx) $display("FAIL count_rx_odd: got %0d want %0d", cnt_rx_o, exp_rx);
    else n_pass++;
    n_checks++;
    if (cnt_pe_e !== exp_pe_e) $display("FAIL count_pe_even: got %0d want %0d", cnt_pe_e, exp_pe_e);
    else n_pass++;
    n_checks++;
    if (cnt_pe_o !== exp_pe_o) $display("FAIL count_pe_odd: got %0d want %0d", cnt_pe_o, exp_pe_o);
    else n_pass++;
    n_checks++;
    if (cnt_fe !== exp_fe) $display("FAIL count_fe: got %0d want %0d", cnt_fe, exp_fe);
    else n_pass++;
    n_checks++;
    if (cnt_oe !== exp_oe) $display("FAIL count_oe: got %0d want %0d", cnt_oe, exp_oe);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_framing();
    test_overrun();
    test_back_to_back();
    test_reset_mid_frame();
    test_random();
    test_pulse_counts();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
